// File: rtl/pr_noc_hub_if.sv
// rtl/pr_noc_hub_if.sv - request/query/reply/response bundle between page-owner nodes and pr_noc_hub
interface pr_noc_hub_if #(
    parameter int NUM_ANTS = 4,
    parameter int PAGE_W   = 6,
    parameter int WIDTH    = 16
);
    logic [NUM_ANTS*PAGE_W-1:0] req_bus;
    logic [NUM_ANTS-1:0]        req_valid;
    logic [NUM_ANTS-1:0]        req_ready;
    logic [NUM_ANTS*PAGE_W-1:0] query_bus;
    logic [NUM_ANTS-1:0]        query_valid;
    logic [NUM_ANTS*WIDTH-1:0]  reply_bus;
    logic [WIDTH+PAGE_W-1:0]    response;
    logic                       response_valid;
    logic                       busy;
    logic                       err_page;

    // node side
    modport master (
        output req_bus, req_valid, reply_bus,
        input  req_ready, query_bus, query_valid, response, response_valid, busy, err_page
    );

    // hub side
    modport slave (
        input  req_bus, req_valid, reply_bus,
        output req_ready, query_bus, query_valid, response, response_valid, busy, err_page
    );
endinterface

// File: rtl/pr_noc_hub.sv
// rtl/pr_noc_hub.sv - single-transaction PageRank hub; PR_HUB_STATS_EN adds txn_count/drop_count
module pr_noc_hub #(
    parameter int NUM_ANTS    = 4,
    parameter int LOCAL_PAGES = 16,
    parameter int PAGE_W      = 6,
    parameter int WIDTH       = 16,
    parameter int REPLY_LAT   = 1
) (
    input  logic         clk,
    input  logic         reset,
    pr_noc_hub_if.slave  hub
`ifdef PR_HUB_STATS_EN
    ,
    output logic [15:0]  txn_count,
    output logic [7:0]   drop_count
`endif
);

    localparam int PTR_W     = (NUM_ANTS > 1) ? $clog2(NUM_ANTS) : 1;
    localparam int CNT_W     = (REPLY_LAT > 1) ? $clog2(REPLY_LAT) : 1;
    localparam int NUM_PAGES = NUM_ANTS * LOCAL_PAGES;

    typedef enum logic [1:0] {IDLE, QUERY, WAIT, BCAST} state_t;

    state_t                  state, state_n;
    logic [PTR_W-1:0]        rr_ptr, rr_ptr_n;
    logic [PTR_W-1:0]        owner, owner_n;
    logic [PAGE_W-1:0]       page_q, page_n;
    logic [CNT_W-1:0]        wait_cnt, wait_cnt_n;
    logic [PAGE_W-1:0]       query_arr   [NUM_ANTS];
    logic [PAGE_W-1:0]       query_arr_n [NUM_ANTS];
    logic [NUM_ANTS-1:0]     query_valid, query_valid_n;
    logic [WIDTH+PAGE_W-1:0] response, response_n;
    logic                    response_valid, response_valid_n;
    logic                    busy, busy_n;
    logic                    err_page, err_page_n;

    logic [PAGE_W-1:0]       req_page  [NUM_ANTS];
    logic [WIDTH-1:0]        reply_arr [NUM_ANTS];
    logic [NUM_ANTS-1:0]     req_ready;
    logic [PTR_W-1:0]        cand;
    logic [PTR_W-1:0]        grant_idx;
    logic                    grant_found;
    logic [PAGE_W-1:0]       grant_page;
    logic [PTR_W-1:0]        grant_owner;
    logic                    grant_oor;

    for (genvar g = 0; g < NUM_ANTS; g++) begin : g_slice
        assign req_page[g]                        = hub.req_bus[g*PAGE_W +: PAGE_W];
        assign reply_arr[g]                       = hub.reply_bus[g*WIDTH +: WIDTH];
        assign hub.query_bus[g*PAGE_W +: PAGE_W]  = query_arr[g];
    end

    assign hub.req_ready      = req_ready;
    assign hub.query_valid    = query_valid;
    assign hub.response       = response;
    assign hub.response_valid = response_valid;
    assign hub.busy           = busy;
    assign hub.err_page       = err_page;

    // Rotating priority: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NUM_ANTS; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NUM_ANTS);
            if (!grant_found && hub.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign grant_page  = req_page[grant_idx];
    assign grant_oor   = int'(grant_page) >= NUM_PAGES;
    assign grant_owner = PTR_W'(int'(grant_page) / LOCAL_PAGES);

    always_comb begin
        req_ready = '0;
        if (!reset && state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_n          = state;
        rr_ptr_n         = rr_ptr;
        owner_n          = owner;
        page_n           = page_q;
        wait_cnt_n       = wait_cnt;
        query_arr_n      = query_arr;
        query_valid_n    = '0;
        response_n       = response;
        response_valid_n = 1'b0;
        err_page_n       = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    rr_ptr_n = (int'(grant_idx) == NUM_ANTS - 1) ? '0 : grant_idx + 1'b1;
                    page_n   = grant_page;
                    owner_n  = grant_owner;
                    if (grant_oor) begin
                        err_page_n = 1'b1;
                    end else begin
                        state_n                    = QUERY;
                        query_arr_n[grant_owner]   = grant_page;
                        query_valid_n[grant_owner] = 1'b1;
                    end
                end
            end
            QUERY: begin
                state_n    = WAIT;
                wait_cnt_n = CNT_W'(REPLY_LAT - 1);
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_n          = BCAST;
                    response_n       = {reply_arr[owner], page_q};
                    response_valid_n = 1'b1;
                    query_arr_n      = '{default: '0};
                end else begin
                    wait_cnt_n = wait_cnt - 1'b1;
                end
            end
            BCAST: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            page_q         <= '0;
            wait_cnt       <= '0;
            query_arr      <= '{default: '0};
            query_valid    <= '0;
            response       <= '0;
            response_valid <= 1'b0;
            busy           <= 1'b0;
            err_page       <= 1'b0;
        end else begin
            state          <= state_n;
            rr_ptr         <= rr_ptr_n;
            owner          <= owner_n;
            page_q         <= page_n;
            wait_cnt       <= wait_cnt_n;
            query_arr      <= query_arr_n;
            query_valid    <= query_valid_n;
            response       <= response_n;
            response_valid <= response_valid_n;
            busy           <= busy_n;
            err_page       <= err_page_n;
        end
    end

`ifdef PR_HUB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txn_count  <= '0;
            drop_count <= '0;
        end else begin
            if (response_valid && txn_count != 16'hFFFF) begin
                txn_count <= txn_count + 16'd1;
            end
            if (err_page && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end
`endif

endmodule
